change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//   Downstream stage of the FSM change calculator. Accepts the computed change
//   amount and pays it out one coin at a time through a valid/ready handshake
//   with the coin-ejector mechanism. Coin selection is greedy: the largest coin
//   that fits is issued first. Reports coins issued, the remaining balance and
//   completion.
// PARAMETERS
//   WIDTH     5   width of change, remaining and coin_count
//   COIN_HI   10  value of the large coin
//   COIN_MID  5   value of the medium coin
//   COIN_LO   1   value of the small coin; must be 1 so greedy always terminates
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      reset: asynchronous, active-low (0 = reset)
//   start       in   1      1-cycle request to load change; honoured only in IDLE
//   change      in   WIDTH  amount to dispense; sampled when start is accepted
//   abort       in   1      stop dispensing early; ignored outside DISPENSE
//   coin_ready  in   1      ejector can take a coin this cycle
//   coin_valid  out  1      a coin request is presented
//   coin_sel    out  2      00 none, 01 LO, 10 MID, 11 HI
//   busy        out  1      high in DISPENSE and DONE
//   done        out  1      1-cycle pulse at end of transaction
//   remaining   out  WIDTH  balance not yet dispensed
//   coin_count  out  WIDTH  coins issued in the current transaction
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset: state=IDLE, all outputs 0. Asserting rst mid-dispense clears the
//     outputs immediately, without waiting for an edge. The pending coin is dropped.
//   - States: IDLE, DISPENSE, DONE. All outputs are registered or decoded from
//     state only; there is no combinational path from an input to an output.
//   - IDLE: start=1 loads remaining<=change and coin_count<=0.
//       change!=0 -> DISPENSE; change==0 -> DONE.
//   - DISPENSE: coin_valid=1. coin_sel is the greedy pick:
//       HI if remaining>=COIN_HI, else MID if remaining>=COIN_MID, else LO.
//     - A transfer occurs when coin_valid & coin_ready at a clock edge. On a transfer,
//       remaining -= coin value and coin_count += 1.
//     - If the new remaining is 0, go to DONE.
//     - With coin_ready=0, coin_sel, remaining and coin_count hold stable.
//   - abort in DISPENSE -> DONE and remaining is kept, so it stays nonzero.
//     If abort and a transfer fall in the same cycle, the transfer is applied first.
//   - DONE: done=1 and coin_valid=0 for exactly one cycle, then IDLE.
//     remaining and coin_count hold until the next accepted start.
//   - start outside IDLE is ignored and does not change change/remaining.
//   - Latency: start accepted at edge N -> coin_valid high in the cycle after
//     edge N. With coin_ready held at 1, one coin is issued per cycle, and done
//     rises in the cycle after the edge that takes the last coin.
//   - Arithmetic: unsigned WIDTH bits. Because greedy never picks a coin larger
//     than remaining, subtraction never underflows. change up to 2^WIDTH-1 (31) is legal.
// TESTING
//   1. rst=0 for 2 cycles, then rst=1 -> all outputs 0, state IDLE.
//   2. change=5, start, coin_ready=1 -> one coin MID, coin_count=1, remaining=0,
//      and a single done pulse 2 cycles after start.
//   3. change=23, coin_ready=1 -> coin sequence HI,HI,LO,LO,LO, coin_count=5,
//      remaining=0, done pulse.
//   4. change=6, coin_ready=0 for 3 cycles -> coin_valid=1, coin_sel=MID and
//      remaining=6 stay stable. Then coin_ready=1 -> coins MID then LO, done.
//   5. change=0, start -> coin_valid never rises, done pulse next cycle, coin_count=0.
//      Separately: change=31 and start, then abort after the first HI ->
//      remaining=21, coin_count=1, done. A start pulse during DISPENSE is ignored.
//   6. change=20 and start, then rst=0 asserted between clock edges after the
//      first coin -> coin_valid, busy and remaining drop to 0 immediately.
//      After release, the block sits in IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin per valid/ready transfer, largest coin first.
// Tracks the balance still owed and the number of coins issued, and pulses done at the end.
module change_dispenser #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned COIN_HI  = 10,
  parameter int unsigned COIN_MID = 5,
  parameter int unsigned COIN_LO  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] change,
  input  logic             abort,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] coin_count,
  output logic [1:0]       dbg_state
);

  // Handshake: a coin moves on a rising edge where coin_valid && coin_ready.
  // coin_valid never waits on coin_ready, and coin_sel is held while a coin is refused.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_MID  = 2'b10;
  localparam logic [1:0] SEL_HI   = 2'b11;

  localparam logic [WIDTH-1:0] HI_V  = WIDTH'(COIN_HI);
  localparam logic [WIDTH-1:0] MID_V = WIDTH'(COIN_MID);
  localparam logic [WIDTH-1:0] LO_V  = WIDTH'(COIN_LO);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       pick;
  logic [WIDTH-1:0] pick_val;
  logic             xfer;

  // Greedy pick depends only on the registered balance, so coin_sel has no input path.
  always_comb begin
    pick     = SEL_LO;
    pick_val = LO_V;
    if (rem_q >= HI_V) begin
      pick     = SEL_HI;
      pick_val = HI_V;
    end else if (rem_q >= MID_V) begin
      pick     = SEL_MID;
      pick_val = MID_V;
    end
  end

  assign xfer = (state_q == S_DISPENSE) && coin_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = change;
          cnt_d   = '0;
          state_d = (change == '0) ? S_DONE : S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        // A transfer in the abort cycle still counts; abort only ends the payout.
        if (xfer) begin
          rem_d = rem_q - pick_val;
          cnt_d = cnt_q + ONE_V;
        end
        if (abort || (rem_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    coin_valid = (state_q == S_DISPENSE);
    coin_sel   = (state_q == S_DISPENSE) ? pick : SEL_NONE;
    busy       = (state_q == S_DISPENSE) || (state_q == S_DONE);
    done       = (state_q == S_DONE);
    remaining  = rem_q;
    coin_count = cnt_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed cases plus randomized transactions,
// scored against a greedy coin list computed with plain division and remainder.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] change;
  logic       abort;
  logic       coin_ready;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [4:0] remaining;
  logic [4:0] coin_count;
  logic [1:0] dbg_state;

  int total;
  int bad;

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .change     (change),
    .abort      (abort),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .coin_count (coin_count),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block: rising edges at 5, 15, 25 ...; inputs move and outputs are read on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int coin_value(input logic [1:0] sel);
    case (sel)
      2'b11:   return 10;
      2'b10:   return 5;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  task automatic check_idle(input string tag, input int exp_rem, input int exp_cnt);
    chk({tag, "_valid"}, coin_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sel"}, coin_sel, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_rem"}, remaining, exp_rem);
    chk({tag, "_cnt"}, coin_count, exp_cnt);
  endtask

  // Driver + scoreboard for one transaction. Called at a falling edge with the DUT idle.
  // hold_cycles: coin_ready forced low for this many dispense cycles first.
  // abort_at: assert abort in the cycle where this many coins have been taken (-1 = never).
  // abort_xfer: whether coin_ready is also high in that abort cycle.
  task automatic run_txn(input int chg, input int rdy_pct, input int hold_cycles,
                         input int abort_at, input bit abort_xfer);
    logic [1:0] exp_q[$];
    int         rem;
    int         cnt;
    int         cyc;
    bit         exp_done;
    bit         fin;
    exp_q.delete();
    for (int i = 0; i < chg / 10; i++) exp_q.push_back(2'b11);
    if ((chg % 10) >= 5) exp_q.push_back(2'b10);
    for (int i = 0; i < chg % 5; i++) exp_q.push_back(2'b01);
    rem      = chg;
    cnt      = 0;
    exp_done = (chg == 0);
    fin      = 1'b0;

    change = chg[4:0];
    start  = 1'b1;
    step();
    start = 1'b0;

    for (cyc = 0; cyc < 200 && !fin; cyc++) begin
      chk("done", done, exp_done);
      chk("rem", remaining, rem);
      chk("cnt", coin_count, cnt);
      chk("busy", busy, 1);
      if (exp_done) begin
        chk("done_valid", coin_valid, 0);
        chk("done_sel", coin_sel, 0);
        if (abort_at < 0) chk("done_left", exp_q.size(), 0);
        fin = 1'b1;
      end else begin
        chk("valid", coin_valid, 1);
        chk("sel", coin_sel, (exp_q.size() != 0) ? exp_q[0] : 2'b00);
        coin_ready = (cyc >= hold_cycles) && ($urandom_range(0, 99) < rdy_pct);
        abort      = (abort_at >= 0) && (cnt == abort_at);
        if (abort) coin_ready = abort_xfer;
        // Stray starts while busy must not disturb the payout.
        start  = ($urandom_range(0, 5) == 0);
        change = 5'($urandom_range(0, 31));
        if (coin_ready && exp_q.size() != 0) begin
          rem -= coin_value(exp_q.pop_front());
          cnt++;
        end
        if (abort || rem == 0) exp_done = 1'b1;
      end
      step();
      coin_ready = 1'b0;
      abort      = 1'b0;
      start      = 1'b0;
    end
    if (!fin) chk("timeout", 0, 1);
    check_idle("post", rem, cnt);
    // abort in IDLE has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("idle_abort", rem, cnt);
  endtask

  initial begin
    int nc;
    int ab;
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    start      = 1'b0;
    change     = '0;
    abort      = 1'b0;
    coin_ready = 1'b0;

    step();
    step();
    check_idle("in_reset", 0, 0);
    rst = 1'b1;
    step();
    check_idle("reset", 0, 0);

    run_txn(5, 100, 0, -1, 1'b0);
    run_txn(23, 100, 0, -1, 1'b0);
    run_txn(6, 100, 3, -1, 1'b0);
    run_txn(0, 100, 0, -1, 1'b0);
    run_txn(31, 100, 0, 1, 1'b0);
    run_txn(31, 100, 0, 1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      int chg;
      chg = $urandom_range(0, 31);
      nc  = chg / 10 + ((chg % 10) >= 5 ? 1 : 0) + chg % 5;
      ab  = (nc > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, nc - 1) : -1;
      run_txn(chg, $urandom_range(30, 100), $urandom_range(0, 2), ab, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a payout.
    change = 5'd20;
    start  = 1'b1;
    step();
    start      = 1'b0;
    coin_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_cnt", coin_count, 1);
    chk("pre_rst_rem", remaining, 10);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", coin_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rem", remaining, 0);
    chk("arst_cnt", coin_count, 0);
    chk("arst_sel", coin_sel, 0);
    @(negedge clk);
    coin_ready = 1'b0;
    rst        = 1'b1;
    step();
    check_idle("after_arst", 0, 0);
    step();
    check_idle("after_arst2", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
